// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring radix-2 divider, signed or unsigned.
//
// Ports
//   clk, rst          clock and synchronous active-high reset
//   div_begin         start request, accepted only in IDLE
//   div_sign          1 = two's complement operands, 0 = unsigned
//   div_flush         abort; returns to IDLE with no completion pulse
//   div_dividend      dividend, WIDTH bits
//   div_divisor       divisor, WIDTH bits
//   div_quotient      registered quotient, held between operations
//   div_remainder     registered remainder, held between operations
//   div_busy          high in CALC and FIX
//   div_done          one-cycle completion pulse
//   div_by_zero       qualified by div_done, divisor was zero
//
// Operation is accepted at edge 0. CALC runs on edges 1..WIDTH, FIX runs on
// edge WIDTH+1, and div_done is high in the following cycle. A zero divisor
// waits in IDLE for one cycle and completes at edge 1 without raising busy.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_begin,
  input  logic             div_sign,
  input  logic             div_flush,
  input  logic [WIDTH-1:0] div_dividend,
  input  logic [WIDTH-1:0] div_divisor,
  output logic [WIDTH-1:0] div_quotient,
  output logic [WIDTH-1:0] div_remainder,
  output logic             div_busy,
  output logic             div_done,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend magnitude, becomes quotient
  logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
  logic             q_sign_q, q_sign_d;
  logic             r_sign_q, r_sign_d;
  logic             zero_q, zero_d;   // divide-by-zero completion pending
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             byz_q, byz_d;

  // Operand sign handling on acceptance
  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;

  assign dvd_neg = div_sign & div_dividend[WIDTH-1];
  assign dvs_neg = div_sign & div_divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -div_dividend : div_dividend;
  assign dvs_mag = dvs_neg ? -div_divisor  : div_divisor;

  // One restoring step: the MSB of the WIDTH+1-bit difference is the borrow,
  // since the partial remainder is always below the divisor.
  logic [WIDTH:0] shift_rem;
  logic [WIDTH:0] sub_res;
  logic           borrow;

  assign shift_rem = {rem_q, dvd_q[WIDTH-1]};
  assign sub_res   = shift_rem - {1'b0, dvs_q};
  assign borrow    = sub_res[WIDTH];

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    q_sign_d = q_sign_q;
    r_sign_d = r_sign_q;
    zero_d   = zero_q;
    quot_d   = quot_q;
    remo_d   = remo_q;
    byz_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (div_flush) begin
          zero_d = 1'b0;
        end else if (zero_q) begin
          state_d = DONE;
          zero_d  = 1'b0;
          quot_d  = '1;
          remo_d  = dvd_q;
          byz_d   = 1'b1;
        end else if (div_begin) begin
          if (div_divisor == '0) begin
            zero_d = 1'b1;
            dvd_d  = div_dividend;
          end else begin
            state_d  = CALC;
            cnt_d    = CW'(WIDTH);
            dvd_d    = dvd_mag;
            dvs_d    = dvs_mag;
            rem_d    = '0;
            q_sign_d = dvd_neg ^ dvs_neg;
            r_sign_d = dvd_neg;
          end
        end
      end

      CALC: begin
        if (div_flush) begin
          state_d = IDLE;
        end else begin
          rem_d = borrow ? shift_rem[WIDTH-1:0] : sub_res[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], ~borrow};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = FIX;
          end
        end
      end

      FIX: begin
        if (div_flush) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          quot_d  = q_sign_q ? -dvd_q : dvd_q;
          remo_d  = r_sign_q ? -rem_q : rem_q;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      q_sign_q <= 1'b0;
      r_sign_q <= 1'b0;
      zero_q   <= 1'b0;
      quot_q   <= '0;
      remo_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      byz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      q_sign_q <= q_sign_d;
      r_sign_q <= r_sign_d;
      zero_q   <= zero_d;
      quot_q   <= quot_d;
      remo_q   <= remo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      byz_q    <= byz_d;
    end
  end

  assign div_quotient  = quot_q;
  assign div_remainder = remo_q;
  assign div_busy      = busy_q;
  assign div_done      = done_q;
  assign div_by_zero   = byz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider (WIDTH=32) with a result
// scoreboard: expected results are queued at issue and popped on div_done.
module tb_seq_divider;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = W + 1;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         bz;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         div_begin;
  logic         div_sign;
  logic         div_flush;
  logic [W-1:0] div_dividend;
  logic [W-1:0] div_divisor;
  logic [W-1:0] div_quotient;
  logic [W-1:0] div_remainder;
  logic         div_busy;
  logic         div_done;
  logic         div_by_zero;

  exp_t         sb[$];
  int unsigned  n_cmp;
  int unsigned  n_bad;
  logic [W-1:0] last_q;
  logic [W-1:0] last_r;

  seq_divider #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .div_begin    (div_begin),
    .div_sign     (div_sign),
    .div_flush    (div_flush),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder),
    .div_busy     (div_busy),
    .div_done     (div_done),
    .div_by_zero  (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic bz);
    exp_t e;
    e.q  = q;
    e.r  = r;
    e.bz = bz;
    return e;
  endfunction

  // Behavioural reference: truncating division, remainder follows dividend.
  function automatic exp_t ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa;
    longint sd;
    e.bz = 1'b0;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.bz = 1'b1;
    end else if (s) begin
      sa  = longint'($signed(a));
      sd  = longint'($signed(b));
      e.q = W'(sa / sd);
      e.r = W'(sa % sd);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Drive a begin so that it is sampled at edge 0; returns just after edge 0.
  task automatic start(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    div_begin    = 1'b1;
    div_sign     = s;
    div_dividend = a;
    div_divisor  = b;
    @(negedge clk);
    div_begin    = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
    int   n;
    int   busy_cnt;
    bit   seen;
    exp_t e;
    n        = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    for (int i = 0; i <= 120; i++) begin
      if (i > 0) @(negedge clk);
      if (div_done) begin
        seen = 1'b1;
        n    = i;
        break;
      end
      if (div_busy) busy_cnt++;
    end
    check({tag, "/done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({tag, "/latency"}, 64'(n), 64'(exp_lat));
      check({tag, "/busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
      check({tag, "/sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check({tag, "/q"}, 64'(div_quotient), 64'(e.q));
        check({tag, "/r"}, 64'(div_remainder), 64'(e.r));
        check({tag, "/by_zero"}, 64'(div_by_zero), 64'(e.bz));
        last_q = e.q;
        last_r = e.r;
        @(negedge clk);
        check({tag, "/done_pulse"}, 64'(div_done), 64'd0);
        check({tag, "/q_hold"}, 64'(div_quotient), 64'(e.q));
      end
    end else if (sb.size() != 0) begin
      void'(sb.pop_front());
    end
  endtask

  task automatic do_op(input string tag, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input exp_t e);
    sb.push_back(e);
    start(s, a, b);
    if (b == '0) wait_done(tag, 1, 0);
    else         wait_done(tag, int'(LAT), int'(LAT));
  endtask

  initial begin
    int           pulses;
    int           first_idx;
    int           second_idx;
    int           dcnt;
    logic         rs;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    exp_t         e;

    n_cmp        = 0;
    n_bad        = 0;
    last_q       = '0;
    last_r       = '0;
    rst          = 1'b1;
    div_begin    = 1'b0;
    div_sign     = 1'b0;
    div_flush    = 1'b0;
    div_dividend = '0;
    div_divisor  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst/q", 64'(div_quotient), 64'd0);
    check("rst/r", 64'(div_remainder), 64'd0);
    check("rst/busy", 64'(div_busy), 64'd0);
    check("rst/done", 64'(div_done), 64'd0);
    check("rst/by_zero", 64'(div_by_zero), 64'd0);
    rst = 1'b0;

    // Directed vectors with hand-derived results
    do_op("u100_7",     1'b0, 32'd100,        32'd7,          mk(32'd14, 32'd2, 1'b0));
    do_op("s-7_2",      1'b1, 32'hFFFF_FFF9,  32'd2,          mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0));
    do_op("s_ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  mk(32'h8000_0000, 32'd0, 1'b0));
    do_op("s5_0",       1'b1, 32'd5,          32'd0,          mk(32'hFFFF_FFFF, 32'd5, 1'b1));
    do_op("u5_0",       1'b0, 32'd5,          32'd0,          mk(32'hFFFF_FFFF, 32'd5, 1'b1));
    do_op("s7_-2",      1'b1, 32'd7,          32'hFFFF_FFFE,  mk(32'hFFFF_FFFD, 32'd1, 1'b0));
    do_op("u_big_2",    1'b0, 32'hFFFF_FFF9,  32'd2,          mk(32'h7FFF_FFFC, 32'd1, 1'b0));
    do_op("u7_100",     1'b0, 32'd7,          32'd100,        mk(32'd0, 32'd7, 1'b0));
    do_op("u_max_1",    1'b0, 32'hFFFF_FFFF,  32'd1,          mk(32'hFFFF_FFFF, 32'd0, 1'b0));
    do_op("s_min_2",    1'b1, 32'h8000_0000,  32'd2,          mk(32'hC000_0000, 32'd0, 1'b0));
    do_op("s-100_0",    1'b1, 32'hFFFF_FF9C,  32'd0,          mk(32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1));

    // Random operands against the behavioural reference
    for (int k = 0; k < 6; k++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (rb == '0) rb = 32'd1;
      do_op("rand", rs, ra, rb, ref_div(rs, ra, rb));
    end

    // Flush sampled at edge 10: no pulse, outputs keep prior values
    start(1'b0, 32'd1000, 32'd3);
    dcnt = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (div_done) dcnt++;
    end
    div_flush = 1'b1;
    @(negedge clk);
    div_flush = 1'b0;
    check("flush/busy", 64'(div_busy), 64'd0);
    check("flush/done", 64'(div_done), 64'd0);
    check("flush/early_done", 64'(dcnt), 64'd0);
    check("flush/q_kept", 64'(div_quotient), 64'(last_q));
    check("flush/r_kept", 64'(div_remainder), 64'(last_r));
    do_op("after_flush", 1'b0, 32'd1000, 32'd3, mk(32'd333, 32'd1, 1'b0));

    // Flush wins over begin in the same cycle
    @(negedge clk);
    div_begin    = 1'b1;
    div_flush    = 1'b1;
    div_sign     = 1'b0;
    div_dividend = 32'd9;
    div_divisor  = 32'd3;
    @(negedge clk);
    div_begin = 1'b0;
    div_flush = 1'b0;
    check("flush_prio/busy", 64'(div_busy), 64'd0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (div_done) dcnt++;
    end
    check("flush_prio/no_done", 64'(dcnt), 64'd0);
    check("flush_prio/q_kept", 64'(div_quotient), 64'(last_q));

    // Begin held high for 80 cycles: restarts only from IDLE after DONE
    sb.push_back(mk(32'd3, 32'd0, 1'b0));
    sb.push_back(mk(32'd3, 32'd0, 1'b0));
    pulses     = 0;
    first_idx  = -1;
    second_idx = -1;
    @(negedge clk);
    div_begin    = 1'b1;
    div_sign     = 1'b0;
    div_dividend = 32'd9;
    div_divisor  = 32'd3;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (div_done) begin
        pulses++;
        if (pulses == 1) first_idx = i;
        if (pulses == 2) second_idx = i;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("held/q", 64'(div_quotient), 64'(e.q));
          check("held/r", 64'(div_remainder), 64'(e.r));
          check("held/by_zero", 64'(div_by_zero), 64'(e.bz));
        end
      end
    end
    div_begin = 1'b0;
    div_flush = 1'b1;
    @(negedge clk);
    div_flush = 1'b0;
    check("held/pulses", 64'(pulses), 64'd2);
    check("held/first_idx", 64'(first_idx), 64'(LAT));
    check("held/spacing", 64'(second_idx - first_idx), 64'(LAT + 2));
    last_q = 32'd3;
    last_r = 32'd0;

    // Reset sampled at edge 20 abandons the operation
    start(1'b1, 32'hFFFF_FF9C, 32'd7);
    for (int i = 1; i <= 19; i++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst/q", 64'(div_quotient), 64'd0);
    check("mid_rst/r", 64'(div_remainder), 64'd0);
    check("mid_rst/busy", 64'(div_busy), 64'd0);
    check("mid_rst/done", 64'(div_done), 64'd0);
    check("mid_rst/by_zero", 64'(div_by_zero), 64'd0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (div_done) dcnt++;
    end
    check("mid_rst/no_done", 64'(dcnt), 64'd0);
    do_op("after_rst", 1'b1, 32'hFFFF_FF9C, 32'd7, mk(32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
